// File: rtl/twc_pkg.sv
// twc_pkg: shared widths, FSM state encoding, multiplier latency and the
// fixed order in which the four real partial products are issued.
package twc_pkg;

  localparam int A_W_DEF            = 8;
  localparam int W_W_DEF            = 9;
  localparam int P_W_DEF            = 17;
  localparam int MUL_LATENCY        = 18;
  // Flush must outlast one full stale multiplier operation plus its valid pulse.
  localparam int FLUSH_CYCLES_DEF   = MUL_LATENCY + 2;
  localparam int TIMEOUT_CYCLES_DEF = 32;

  typedef enum logic [2:0] {
    ST_FLUSH  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_GAP    = 3'd4,
    ST_OUTPUT = 3'd5
  } twc_state_e;

  // Product order: k0 = a_re*w_re, k1 = a_im*w_im, k2 = a_re*w_im, k3 = a_im*w_re.
  localparam logic [1:0] K_RE_RE = 2'd0;
  localparam logic [1:0] K_IM_IM = 2'd1;
  localparam logic [1:0] K_RE_IM = 2'd2;
  localparam logic [1:0] K_IM_RE = 2'd3;
  localparam logic [1:0] K_LAST  = K_IM_RE;

  // Operand 0 is the imaginary sample component for k1 and k3.
  function automatic logic op0_is_im(input logic [1:0] k);
    return (k == K_IM_IM) || (k == K_IM_RE);
  endfunction

  // Operand 1 is the imaginary twiddle component for k1 and k2.
  function automatic logic op1_is_im(input logic [1:0] k);
    return (k == K_IM_IM) || (k == K_RE_IM);
  endfunction

  // Only a_im*w_im is subtracted (from the real part).
  function automatic logic acc_sub(input logic [1:0] k);
    return (k == K_IM_IM);
  endfunction

  // The cross products k2 and k3 feed the imaginary accumulator.
  function automatic logic acc_to_im(input logic [1:0] k);
    return (k == K_RE_IM) || (k == K_IM_RE);
  endfunction

endpackage

// File: rtl/twc_accum.sv
// twc_accum: real/imaginary (P_W+1)-bit accumulators with synchronous clear,
// add/subtract select and target select. nxt_*_o expose the post-update value
// so the parent can register the final result in the same cycle as capture.
module twc_accum
  import twc_pkg::*;
#(
  parameter int P_W = P_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         sub_i,
  input  logic         sel_im_i,
  input  logic [P_W-1:0] p_i,
  output logic [P_W:0] nxt_re_o,
  output logic [P_W:0] nxt_im_o
);

  logic [P_W:0] acc_re_q;
  logic [P_W:0] acc_im_q;
  logic [P_W:0] p_ext;
  logic [P_W:0] addend;

  // Sign-extend the product; wraparound is modulo 2^(P_W+1).
  assign p_ext    = {p_i[P_W-1], p_i};
  assign addend   = sub_i ? (-p_ext) : p_ext;
  assign nxt_re_o = (en_i && !sel_im_i) ? (acc_re_q + addend) : acc_re_q;
  assign nxt_im_o = (en_i &&  sel_im_i) ? (acc_im_q + addend) : acc_im_q;

  // Accumulator registers: clear on new operand accept, otherwise take next value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else if (clr_i) begin
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else begin
      acc_re_q <= nxt_re_o;
      acc_im_q <= nxt_im_o;
    end
  end

endmodule

// File: rtl/twiddle_cmul_ctrl.sv
// twiddle_cmul_ctrl: computes y = a*w by time-sharing one external sequential
// multiplier (start / data_valid handshake), issuing four real products with a
// mandatory idle cycle between them and accumulating into re/im.
// Optional feature macro: CMUL_TIMEOUT_EN (WAIT-state timeout with sticky err).
module twiddle_cmul_ctrl
  import twc_pkg::*;
#(
  parameter int A_W            = A_W_DEF,
  parameter int W_W            = W_W_DEF,
  parameter int P_W            = P_W_DEF,
  parameter int FLUSH_CYCLES   = FLUSH_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a_re,
  input  logic [A_W-1:0] a_im,
  input  logic [W_W-1:0] w_re,
  input  logic [W_W-1:0] w_im,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W:0]   y_re,
  output logic [P_W:0]   y_im,
  output logic           busy,
  output logic           err,
  output logic           mul_start,
  output logic [A_W-1:0] mul_in0,
  output logic [W_W-1:0] mul_in1,
  input  logic           mul_valid,
  input  logic [P_W-1:0] mul_out
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  twc_state_e     state_q;
  logic [FC_W-1:0] flush_cnt_q;
  logic [1:0]     k_q;
  logic [1:0]     k_next;
  logic [A_W-1:0] a_re_q;
  logic [A_W-1:0] a_im_q;
  logic [W_W-1:0] w_re_q;
  logic [W_W-1:0] w_im_q;
  logic           mul_valid_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;
  logic           mul_start_q;
  logic [A_W-1:0] mul_in0_q;
  logic [W_W-1:0] mul_in1_q;
  logic [P_W:0]   y_re_q;
  logic [P_W:0]   y_im_q;
  logic [P_W:0]   acc_re_nxt;
  logic [P_W:0]   acc_im_nxt;
  logic           accept;
  logic           mul_done;
  logic           capture;

`ifdef CMUL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] wait_cnt_q;
  logic            err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // A valid level already high on WAIT entry is stale; only a rising edge counts.
  assign mul_done = mul_valid & ~mul_valid_q;
  assign accept   = in_valid & in_ready_q;
  assign capture  = (state_q == ST_WAIT) & mul_done;
  assign k_next   = k_q + 2'd1;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign mul_start = mul_start_q;
  assign mul_in0   = mul_in0_q;
  assign mul_in1   = mul_in1_q;
  assign y_re      = y_re_q;
  assign y_im      = y_im_q;

  twc_accum #(
    .P_W (P_W)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (accept),
    .en_i     (capture),
    .sub_i    (acc_sub(k_q)),
    .sel_im_i (acc_to_im(k_q)),
    .p_i      (mul_out),
    .nxt_re_o (acc_re_nxt),
    .nxt_im_o (acc_im_nxt)
  );

  // Sequencer FSM with all handshake and multiplier-facing outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= '0;
      k_q         <= 2'd0;
      a_re_q      <= '0;
      a_im_q      <= '0;
      w_re_q      <= '0;
      w_im_q      <= '0;
      mul_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
      mul_in0_q   <= '0;
      mul_in1_q   <= '0;
      y_re_q      <= '0;
      y_im_q      <= '0;
`ifdef CMUL_TIMEOUT_EN
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      mul_valid_q <= mul_valid;
      mul_start_q <= 1'b0;
      case (state_q)
        ST_FLUSH: begin
          if (flush_cnt_q == FC_W'(FLUSH_CYCLES - 1)) begin
            flush_cnt_q <= '0;
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (in_valid) begin
            a_re_q      <= a_re;
            a_im_q      <= a_im;
            w_re_q      <= w_re;
            w_im_q      <= w_im;
            k_q         <= K_RE_RE;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            mul_start_q <= 1'b1;
            mul_in0_q   <= a_re;
            mul_in1_q   <= w_re;
            state_q     <= ST_ISSUE;
`ifdef CMUL_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
`ifdef CMUL_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        ST_WAIT: begin
          if (mul_done) begin
            if (k_q == K_LAST) begin
              out_valid_q <= 1'b1;
              y_re_q      <= acc_re_nxt;
              y_im_q      <= acc_im_nxt;
              state_q     <= ST_OUTPUT;
            end else begin
              state_q <= ST_GAP;
            end
          end
`ifdef CMUL_TIMEOUT_EN
          else if (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 2)) begin
            err_q       <= 1'b1;
            out_valid_q <= 1'b1;
            y_re_q      <= '0;
            y_im_q      <= '0;
            state_q     <= ST_OUTPUT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        ST_GAP: begin
          k_q         <= k_next;
          mul_start_q <= 1'b1;
          mul_in0_q   <= op0_is_im(k_next) ? a_im_q : a_re_q;
          mul_in1_q   <= op1_is_im(k_next) ? w_im_q : w_re_q;
          state_q     <= ST_ISSUE;
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_FLUSH;
        end
      endcase
    end
  end

endmodule
